uart_tx_fifo_gen: RTL and testbench
===================================

Name: uart_tx_fifo_gen

Overview:
- Parametrised successor of the 16550 transmitter; integrates the TX FIFO, the 16x baud divisor and the frame serialiser.
- Host writes bytes into a DEPTH-entry FIFO. The block pops them and emits 16550-format frames on tx.
- Frame options: 5–8 data bits, optional/sticky parity, 1/1.5/2 stop bits, break.
- Sits between the register file (LCR/DLL/DLM/THR fields) and the pad.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DIV_W, 16, divisor width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- divisor  in  DIV_W  clk cycles per 16x baud tick; 0 halts the tick generator
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  8  byte to send
- fifo_clr  in  1  synchronous FIFO flush
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  in  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when wls=00)
- pen  in  1  parity enable
- eps  in  1  even parity select
- sticky_parity  in  1  sticky parity
- set_break  in  1  force tx low
- tx  out  1  serial output
- full  out  1  FIFO full
- thre  out  1  FIFO empty
- temt  out  1  FIFO empty and FSM in IDLE
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overrun  out  1  sticky flag: write attempted while full; cleared by fifo_clr

Behaviour:
- Reset values (rst=0): tx=1, full=0, thre=1, temt=1, level=0, overrun=0, FSM=IDLE, all counters 0.
- Baud generator:
  - Down-counter reloads with divisor. One-clk tick when count reaches 1.
  - divisor=1 gives a tick every clk. divisor=0 gives no ticks; FSM freezes and tx holds.
  - A new divisor value is used at the next reload.
- Bit timing: one bit = 16 ticks; 1.5 stop = 24 ticks.
- FIFO:
  - Write when wr_en && !full. A write while full is dropped and sets overrun.
  - A simultaneous push and pop when full is still a drop; a pop frees space only from the next cycle.
  - level counts 0..DEPTH.
  - fifo_clr empties the FIFO in one cycle. It does not abort the frame in flight. fifo_clr wins over wr_en in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop into the shift register the same cycle, clear the tick/bit counters, go to START.
  - START: tx=0 for 16 ticks.
  - DATA: LSB first. Send wls+5 bits, 16 ticks each. Data is masked to wls bits.
  - PARITY (only if pen=1):
    - sticky_parity=0: bit = ^data if eps=1, else ~^data.
    - sticky_parity=1: bit = ~eps.
    - Lasts 16 ticks.
  - STOP: tx=1 for 16, 24 or 32 ticks. Then go to IDLE.
  - Back-to-back: if the FIFO is non-empty when STOP ends, the next START begins on the following clk.
- Frame-option inputs are sampled at the IDLE→START pop and held for the whole frame.
- set_break: tx=0 combinationally-registered (next clk) while asserted. FSM keeps running; the frame is lost on the line.
- temt = thre && (state==IDLE), registered with state.
- Reset mid-frame: immediate abort, tx=1, FIFO emptied.

Optional Feature:
- Macro UART_TX_CTS_EN.
- When defined:
  - Adds input cts_n (1 bit, active-low clear-to-send, passed through a 2-flop synchroniser).
  - IDLE pops only when the synchronised cts_n==0.
  - Deassertion mid-frame does not stop the current frame.
- When undefined: no port; IDLE pops whenever the FIFO is non-empty.

Test Plan:
- divisor=1, wls=11, pen=0, stb=0; write 0x13 → tx: 16 clk low; data 1,1,0,0,1,0,0,0, 16 clk each; 16 clk high; temt returns to 1 at clk 160 after the pop.
- pen=1, eps=1, stb=1, wls=11, byte 0x13 → parity bit 1; stop high for 32 ticks. With eps=0 → parity 0. With sticky_parity=1, eps=1 → parity 0.
- wls=00, stb=1, pen=0, divisor=3, byte 0x1F → 5 data bits all 1; stop = 24 ticks = 72 clk; upper bits ignored.
- DEPTH=16; write 17 bytes with divisor=0 → level=16, full=1, overrun=1, 17th byte dropped. Set divisor=1 → 16 back-to-back frames, no idle gap, thre=1 after the last pop.
- set_break asserted mid-DATA for 40 clk → tx=0 throughout; FSM completes and temt rises on schedule. fifo_clr mid-frame → level=0 next clk; current frame finishes intact.
- rst pulsed low mid-DATA → tx=1 and level=0 immediately; first frame after release starts cleanly. With UART_TX_CTS_EN: cts_n=1 holds tx=1 with level=3; cts_n=0 → START within 3 clk.

Source files
------------

// File: rtl/uart_tx_fifo_gen.sv
// rtl/uart_tx_fifo_gen.sv - 16550-style UART transmitter with TX FIFO, 16x baud divisor and frame serialiser; optional UART_TX_CTS_EN adds cts_n flow control
`timescale 1ns/1ps
module uart_tx_fifo_gen #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         divisor,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     fifo_clr,
    input  logic [1:0]               wls,
    input  logic                     stb,
    input  logic                     pen,
    input  logic                     eps,
    input  logic                     sticky_parity,
    input  logic                     set_break,
`ifdef UART_TX_CTS_EN
    input  logic                     cts_n,
`endif
    output logic                     tx,
    output logic                     full,
    output logic                     thre,
    output logic                     temt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    // baud generator
    logic [DIV_W-1:0] baud_cnt;
    logic             tick;
    logic             baud_run;

    // serialiser
    state_t      state;
    state_t      state_nxt;
    logic [5:0]  tick_cnt;
    logic [5:0]  tick_cnt_nxt;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_nxt;
    logic [7:0]  shreg;
    logic [7:0]  shreg_nxt;
    logic [5:0]  bit_len;
    logic        bit_end;
    logic        tx_nxt;
    logic        cts_ok;

    // frame options captured at the pop
    logic [1:0]  f_wls;
    logic        f_pen;
    logic [5:0]  f_stop_ticks;
    logic        par_bit;

    // values computed from the live option inputs for the byte being popped
    logic [7:0]  width_mask;
    logic [7:0]  pop_data;
    logic        par_calc;
    logic [5:0]  stop_calc;

    assign full     = (count == LW'(DEPTH));
    assign thre     = (count == '0);
    assign level    = count;
    assign temt     = thre && (state == IDLE);
    assign push     = wr_en && !full && !fifo_clr;
    assign baud_run = (divisor != '0);
    assign tick     = (baud_cnt == DIV_W'(1));

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // two-flop synchroniser for the asynchronous clear-to-send pin; resets to "not clear"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
        end
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    // FIFO data array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overrun; a flush wins over everything else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (!push && pop) begin
                count <= count - LW'(1);
            end
            // full is the registered occupancy, so a pop in the same cycle does not make room
            if (wr_en && full) begin
                overrun <= 1'b1;
            end
        end
    end

    // 16x baud down-counter; restarted at a pop so every bit of a frame has the same width
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (pop || (baud_cnt < DIV_W'(2))) begin
            baud_cnt <= divisor;
        end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
        end
    end

    // data mask, parity and stop length for the byte at the FIFO head
    always_comb begin
        width_mask = 8'hFF;
        unique case (wls)
            2'b00:   width_mask = 8'h1F;
            2'b01:   width_mask = 8'h3F;
            2'b10:   width_mask = 8'h7F;
            default: width_mask = 8'hFF;
        endcase
        pop_data = mem[rd_ptr] & width_mask;
        if (sticky_parity) begin
            par_calc = ~eps;
        end else if (eps) begin
            par_calc = ^pop_data;
        end else begin
            par_calc = ~^pop_data;
        end
        if (!stb) begin
            stop_calc = 6'd16;
        end else if (wls == 2'b00) begin
            stop_calc = 6'd24;
        end else begin
            stop_calc = 6'd32;
        end
    end

    assign bit_len = (state == STOP) ? f_stop_ticks : 6'd16;
    assign bit_end = tick && (tick_cnt == (bit_len - 6'd1));

    // serialiser next-state: IDLE pops without waiting for a tick; a halted baud generator freezes everything
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        pop          = 1'b0;
        if (state == IDLE) begin
            if (!thre && baud_run && cts_ok) begin
                pop          = 1'b1;
                state_nxt    = START;
                tick_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                shreg_nxt    = pop_data;
            end
        end else if (tick) begin
            if (bit_end) begin
                tick_cnt_nxt = '0;
                case (state)
                    START: begin
                        state_nxt = DATA;
                    end
                    DATA: begin
                        if (bit_cnt == {1'b1, f_wls}) begin
                            state_nxt = f_pen ? PARITY : STOP;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            shreg_nxt   = {1'b0, shreg[7:1]};
                        end
                    end
                    PARITY: begin
                        state_nxt = STOP;
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end else begin
                tick_cnt_nxt = tick_cnt + 6'd1;
            end
        end
    end

    // line level for the state being entered, so tx lines up with the state register
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
    end

    // serialiser state, counters and registered line output; break overrides the line only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            tx       <= set_break ? 1'b0 : tx_nxt;
        end
    end

    // frame options are frozen at the pop and held until the next pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_wls        <= 2'b00;
            f_pen        <= 1'b0;
            f_stop_ticks <= 6'd16;
            par_bit      <= 1'b0;
        end else if (pop) begin
            f_wls        <= wls;
            f_pen        <= pen;
            f_stop_ticks <= stop_calc;
            par_bit      <= par_calc;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// tb/tb_uart_tx_fifo_gen.sv - scoreboard bench for uart_tx_fifo_gen
`timescale 1ns/1ps
module tb_uart_tx_fifo_gen;

    localparam int DEPTH = 16;
    localparam int DIV_W = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [DIV_W-1:0]       divisor = 16'd1;
    logic                   wr_en = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic                   fifo_clr = 1'b0;
    logic [1:0]             wls = 2'b11;
    logic                   stb = 1'b0;
    logic                   pen = 1'b0;
    logic                   eps = 1'b0;
    logic                   sticky_parity = 1'b0;
    logic                   set_break = 1'b0;
`ifdef UART_TX_CTS_EN
    logic                   cts_n = 1'b0;
`endif
    logic                   tx;
    logic                   full;
    logic                   thre;
    logic                   temt;
    logic [$clog2(DEPTH):0] level;
    logic                   overrun;

    uart_tx_fifo_gen #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .divisor       (divisor),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .fifo_clr      (fifo_clr),
        .wls           (wls),
        .stb           (stb),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .set_break     (set_break),
`ifdef UART_TX_CTS_EN
        .cts_n         (cts_n),
`endif
        .tx            (tx),
        .full          (full),
        .thre          (thre),
        .temt          (temt),
        .level         (level),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         has_par;
        bit         par;
        int         stop_ticks;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int nbits, input bit hp,
                                input bit p, input int st, input int dv);
        frame_t f;
        f.data       = d;
        f.nbits      = nbits;
        f.has_par    = hp;
        f.par        = p;
        f.stop_ticks = st;
        f.div        = dv;
        exp_q.push_back(f);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int k = 0;
        while (tx !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_start"}, 32'(tx), 32'd0);
    endtask

    task automatic temt_after_start(input string tag, input int req_clk);
        int n = 0;
        while (temt !== 1'b1 && n < req_clk + 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_temt_clk"}, n, req_clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input int req_clk);
        write_byte(d);
        wait_tx_low(tag);
        temt_after_start(tag, req_clk);
    endtask

    // monitor: decode each frame at mid-bit and compare against the scoreboard head
    initial begin : monitor
        logic       tx_prev;
        frame_t     e;
        logic [7:0] got;
        int         bad;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && tx_prev === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit seen, no frame expected");
                end else begin
                    e = exp_q.pop_front();
                    repeat (8 * e.div) @(negedge clk);
                    check("start_bit", 32'(tx), 32'd0);
                    got = 8'h00;
                    for (int i = 0; i < e.nbits; i++) begin
                        repeat (16 * e.div) @(negedge clk);
                        got[i] = tx;
                    end
                    check("frame_data", 32'(got), 32'(e.data));
                    if (e.has_par) begin
                        repeat (16 * e.div) @(negedge clk);
                        check("parity_bit", 32'(tx), 32'(e.par));
                    end
                    repeat (8 * e.div) @(negedge clk);
                    bad = 0;
                    for (int i = 0; i < e.stop_ticks * e.div; i++) begin
                        if (tx !== 1'b1) bad++;
                        if (i != e.stop_ticks * e.div - 1) @(negedge clk);
                    end
                    check("stop_low_clks", bad, 0);
                end
            end
            tx_prev = tx;
        end
    end

    initial begin : stim
        int n;
        int bad;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_thre", 32'(thre), 32'd1);
        check("rst_temt", 32'(temt), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // 8N1 at divisor 1: 10 bits x 16 ticks
        expect_frame(8'h13, 8, 1'b0, 1'b0, 16, 1);
        run_frame("t8n1", 8'h13, 160);

        // parity variants with two stop bits
        pen = 1'b1; eps = 1'b1; stb = 1'b1;
        expect_frame(8'h13, 8, 1'b1, 1'b1, 32, 1);
        run_frame("even_par", 8'h13, 192);
        eps = 1'b0;
        expect_frame(8'h13, 8, 1'b1, 1'b0, 32, 1);
        run_frame("odd_par", 8'h13, 192);
        sticky_parity = 1'b1; eps = 1'b1;
        expect_frame(8'h13, 8, 1'b1, 1'b0, 32, 1);
        run_frame("sticky_eps1", 8'h13, 192);
        eps = 1'b0;
        expect_frame(8'h13, 8, 1'b1, 1'b1, 32, 1);
        run_frame("sticky_eps0", 8'h13, 192);
        sticky_parity = 1'b0;

        // 5-bit words at divisor 3: 1.5 stop bits, and parity over the masked data only
        wls = 2'b00; pen = 1'b0; stb = 1'b1; divisor = 16'd3;
        expect_frame(8'h1F, 5, 1'b0, 1'b0, 24, 3);
        run_frame("w5_stop15", 8'h1F, 360);
        pen = 1'b1; eps = 1'b1; stb = 1'b0;
        expect_frame(8'h01, 5, 1'b1, 1'b1, 16, 3);
        run_frame("w5_mask_par", 8'hE1, 384);

        // fill with the baud generator halted, then drain back-to-back
        wls = 2'b11; pen = 1'b0; eps = 1'b0; stb = 1'b0; divisor = 16'd0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 16, 1);
            write_byte(8'h30 + 8'(i));
        end
        check("fill_level", 32'(level), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overrun", 32'(overrun), 32'd1);
        check("fill_tx_idle", 32'(tx), 32'd1);
        divisor = 16'd1;
        wait_tx_low("drain");
        temt_after_start("drain", 16 * 160 + 15);
        check("drain_thre", 32'(thre), 32'd1);
        check("drain_queue", exp_q.size(), 0);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);

        // break mid-DATA: line held low, frame timing unaffected
        mon_en = 1'b0;
        write_byte(8'h55);
        wait_tx_low("brk");
        n = 0;
        repeat (36) begin
            @(negedge clk);
            n++;
        end
        set_break = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (tx !== 1'b0) bad++;
        end
        set_break = 1'b0;
        check("break_high_clks", bad, 0);
        while (temt !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("brk_temt_clk", n, 160);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // flush mid-frame: queue empties next clk, frame in flight completes
        expect_frame(8'hA3, 8, 1'b0, 1'b0, 16, 1);
        write_byte(8'hA3);
        write_byte(8'h11);
        write_byte(8'h22);
        check("preclr_level", 32'(level), 32'd2);
        wait_tx_low("clr");
        repeat (30) @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        check("clr_level", 32'(level), 32'd0);
        check("clr_thre", 32'(thre), 32'd1);
        n = 0;
        while (temt !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("clr_temt", 32'(temt), 32'd1);
        repeat (50) @(negedge clk);
        check("clr_queue", exp_q.size(), 0);
        check("clr_tx_idle", 32'(tx), 32'd1);

        // asynchronous reset mid-DATA
        mon_en = 1'b0;
        write_byte(8'h77);
        write_byte(8'h88);
        wait_tx_low("rstmid");
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_level", 32'(level), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        expect_frame(8'hA5, 8, 1'b0, 1'b0, 16, 1);
        run_frame("post_rst", 8'hA5, 160);
        repeat (20) @(negedge clk);
        check("post_rst_queue", exp_q.size(), 0);

`ifdef UART_TX_CTS_EN
        // clear-to-send gating
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        write_byte(8'h5A);
        write_byte(8'hC3);
        write_byte(8'h0F);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("cts_hold_low_clks", bad, 0);
        check("cts_hold_level", 32'(level), 32'd3);
        expect_frame(8'h5A, 8, 1'b0, 1'b0, 16, 1);
        expect_frame(8'hC3, 8, 1'b0, 1'b0, 16, 1);
        expect_frame(8'h0F, 8, 1'b0, 1'b0, 16, 1);
        cts_n = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cts_start_clk", n, 3);
        temt_after_start("cts", 3 * 160 + 2);
        check("cts_queue", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
